// File: rtl/alu_decode_stage.sv
// -----------------------------------------------------------------------------
// alu_decode_stage
//
// Decode stage sitting between fetch and execute. It takes RV32I OP and OP-IMM
// instruction words and turns them into the bundle the execute-stage ALU
// consumes: 6-bit function code, register indices, immediate and B-operand
// select. Anything the ALU cannot execute is flagged illegal but still flows
// downstream so the exception can be raised in program order.
//
// Handshake: valid/ready on both sides, all outputs registered. A one-entry
// skid buffer absorbs the instruction that arrives in the same cycle the
// execute stage stalls, so in_ready can itself be a flop without losing
// throughput.
//
// Optional feature macro: ALU_DEC_PERF_EN
//   When defined, two 32-bit wrapping counters are added as outputs:
//   perf_decoded (bundles taken downstream) and perf_illegal (of those, the
//   ones flagged illegal). They are cleared only by n_rst, never by flush.
//
// Ports:
//   clk          clock
//   n_rst        asynchronous active-low reset
//   flush        drop everything held or arriving this cycle (redirect)
//   in_valid     instruction present from fetch
//   in_instr     RV32I instruction word
//   in_ready     stage can accept (registered)
//   out_valid    decoded bundle present
//   out_ready    execute stage accepts
//   out_fn       ALU function code
//   out_rs1      source register 1
//   out_rs2      source register 2 (0 when out_use_imm)
//   out_rd       destination register
//   out_imm      sign-extended I-immediate, or zero-extended shamt for shifts
//   out_use_imm  B operand is the immediate
//   out_illegal  instruction not supported by this ALU
//   perf_decoded bundles accepted downstream     (ALU_DEC_PERF_EN only)
//   perf_illegal illegal bundles accepted        (ALU_DEC_PERF_EN only)
// -----------------------------------------------------------------------------
module alu_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_fn,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_use_imm,
    output logic            out_illegal
`ifdef ALU_DEC_PERF_EN
    ,
    output logic [31:0]     perf_decoded,
    output logic [31:0]     perf_illegal
`endif
);

    // ALU function codes. CMPEQ (6'b000011) and CMPLE (6'b000111) also
    // exist in the ALU but no RV32I OP/OP-IMM instruction maps onto them.
    localparam logic [5:0] FN_NONE  = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b010000;
    localparam logic [5:0] FN_SUB   = 6'b010001;
    localparam logic [5:0] FN_AND   = 6'b101000;
    localparam logic [5:0] FN_OR    = 6'b101110;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLL   = 6'b110000;
    localparam logic [5:0] FN_SRL   = 6'b110001;
    localparam logic [5:0] FN_SRA   = 6'b110011;
    localparam logic [5:0] FN_CMPLT = 6'b000101;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [5:0]      fn;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            illegal;
    } bundle_t;

    // Pure decode of one instruction word. Register fields are always passed
    // through; fn/imm/use_imm are only filled in for a supported encoding.
    function automatic bundle_t decode_instr(input logic [31:0] instr);
        bundle_t    d;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [5:0] fn;
        logic       ok;
        logic       shift;
        opcode    = instr[6:0];
        funct3    = instr[14:12];
        funct7    = instr[31:25];
        d         = '0;
        d.rd      = instr[11:7];
        d.rs1     = instr[19:15];
        d.rs2     = instr[24:20];
        d.illegal = 1'b1;
        fn        = FN_NONE;
        ok        = 1'b0;
        shift     = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE) begin
                            fn = FN_ADD;
                            ok = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            fn = FN_SUB;
                            ok = 1'b1;
                        end else begin
                            ok = 1'b0;
                        end
                    end
                    3'b001: begin fn = FN_SLL;   ok = (funct7 == F7_BASE); end
                    3'b010: begin fn = FN_CMPLT; ok = (funct7 == F7_BASE); end
                    3'b011: begin fn = FN_NONE;  ok = 1'b0; end // SLTU: no unsigned compare
                    3'b100: begin fn = FN_XOR;   ok = (funct7 == F7_BASE); end
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            fn = FN_SRL;
                            ok = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            fn = FN_SRA;
                            ok = 1'b1;
                        end else begin
                            ok = 1'b0;
                        end
                    end
                    3'b110: begin fn = FN_OR;  ok = (funct7 == F7_BASE); end
                    3'b111: begin fn = FN_AND; ok = (funct7 == F7_BASE); end
                    default: begin fn = FN_NONE; ok = 1'b0; end
                endcase
                if (ok) begin
                    d.fn      = fn;
                    d.illegal = 1'b0;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'b000: begin fn = FN_ADD;   ok = 1'b1; end
                    3'b001: begin fn = FN_SLL;   ok = (funct7 == F7_BASE); shift = 1'b1; end
                    3'b010: begin fn = FN_CMPLT; ok = 1'b1; end
                    3'b011: begin fn = FN_NONE;  ok = 1'b0; end // SLTIU: no unsigned compare
                    3'b100: begin fn = FN_XOR;   ok = 1'b1; end
                    3'b101: begin
                        shift = 1'b1;
                        if (funct7 == F7_BASE) begin
                            fn = FN_SRL;
                            ok = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            fn = FN_SRA;
                            ok = 1'b1;
                        end else begin
                            ok = 1'b0;
                        end
                    end
                    3'b110: begin fn = FN_OR;  ok = 1'b1; end
                    3'b111: begin fn = FN_AND; ok = 1'b1; end
                    default: begin fn = FN_NONE; ok = 1'b0; end
                endcase
                if (ok) begin
                    d.fn      = fn;
                    d.illegal = 1'b0;
                    d.use_imm = 1'b1;
                    d.rs2     = 5'd0;
                    // Shifts carry the 5-bit shamt; funct7 lives in the
                    // upper immediate bits and must not be sign-extended.
                    if (shift) begin
                        d.imm = {{(XLEN-5){1'b0}}, instr[24:20]};
                    end else begin
                        d.imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
                    end
                end else begin
                    d.illegal = 1'b1;
                end
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    bundle_t out_bundle_r;
    bundle_t out_bundle_s;
    bundle_t skid_bundle_r;
    bundle_t skid_bundle_s;
    bundle_t dec_s;
    logic    out_valid_r;
    logic    out_valid_s;
    logic    skid_valid_r;
    logic    skid_valid_s;
    logic    in_ready_r;
    logic    in_ready_s;
    logic    in_fire_s;
    logic    out_fire_s;
    logic    out_free_s;

    // Decode the incoming word and derive the handshake events of this cycle.
    always_comb begin
        dec_s      = decode_instr(in_instr);
        in_fire_s  = in_valid & in_ready_r;
        out_fire_s = out_valid_r & out_ready;
        // The output register can be overwritten when empty or being drained.
        out_free_s = ~out_valid_r | out_ready;
    end

    // Next-state for output register and skid entry; flush wins over all.
    always_comb begin
        out_bundle_s  = out_bundle_r;
        out_valid_s   = out_valid_r;
        skid_bundle_s = skid_bundle_r;
        skid_valid_s  = skid_valid_r;
        if (flush) begin
            out_valid_s  = 1'b0;
            skid_valid_s = 1'b0;
        end else if (out_free_s) begin
            // Skid is older than anything at the input; while it is full
            // in_ready is low, so no new word can arrive in that case.
            if (skid_valid_r) begin
                out_bundle_s = skid_bundle_r;
                out_valid_s  = 1'b1;
                skid_valid_s = 1'b0;
            end else if (in_fire_s) begin
                out_bundle_s = dec_s;
                out_valid_s  = 1'b1;
            end else begin
                out_valid_s  = 1'b0;
            end
        end else begin
            // Output stalled: park an arriving word in the skid entry.
            if (in_fire_s) begin
                skid_bundle_s = dec_s;
                skid_valid_s  = 1'b1;
            end else begin
                skid_valid_s  = skid_valid_r;
            end
        end
        in_ready_s = ~skid_valid_s;
    end

    // Pipeline state registers. in_ready stays low during reset and rises on
    // the first clock after release.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_bundle_r  <= '0;
            out_valid_r   <= 1'b0;
            skid_bundle_r <= '0;
            skid_valid_r  <= 1'b0;
            in_ready_r    <= 1'b0;
        end else begin
            out_bundle_r  <= out_bundle_s;
            out_valid_r   <= out_valid_s;
            skid_bundle_r <= skid_bundle_s;
            skid_valid_r  <= skid_valid_s;
            in_ready_r    <= in_ready_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_fn      = out_bundle_r.fn;
    assign out_rs1     = out_bundle_r.rs1;
    assign out_rs2     = out_bundle_r.rs2;
    assign out_rd      = out_bundle_r.rd;
    assign out_imm     = out_bundle_r.imm;
    assign out_use_imm = out_bundle_r.use_imm;
    assign out_illegal = out_bundle_r.illegal;

`ifdef ALU_DEC_PERF_EN
    logic [31:0] perf_decoded_r;
    logic [31:0] perf_illegal_r;

    // Downstream acceptance counters; wrap naturally and ignore flush.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            perf_decoded_r <= 32'd0;
            perf_illegal_r <= 32'd0;
        end else if (out_fire_s) begin
            perf_decoded_r <= perf_decoded_r + 32'd1;
            if (out_bundle_r.illegal) begin
                perf_illegal_r <= perf_illegal_r + 32'd1;
            end else begin
                perf_illegal_r <= perf_illegal_r;
            end
        end else begin
            perf_decoded_r <= perf_decoded_r;
            perf_illegal_r <= perf_illegal_r;
        end
    end

    assign perf_decoded = perf_decoded_r;
    assign perf_illegal = perf_illegal_r;
`else
    // Handshake event only feeds the counters; keep it referenced.
    logic unused_s;
    assign unused_s = out_fire_s;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_fn;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic        out_illegal;
`ifdef ALU_DEC_PERF_EN
    logic [31:0] perf_decoded;
    logic [31:0] perf_illegal;
`endif

    alu_decode_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_fn      (out_fn),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_imm     (out_imm),
        .out_use_imm (out_use_imm),
        .out_illegal (out_illegal)
`ifdef ALU_DEC_PERF_EN
        ,
        .perf_decoded(perf_decoded),
        .perf_illegal(perf_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  fn;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } bund_t;

    // Instructions in flight inside the stage, oldest first (output, then skid).
    bund_t       q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned exp_dec = 0;
    int unsigned exp_ill = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_XOR  = 32'h0020C1B3;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_SRAI = 32'h40335293;
    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_SLTU = 32'h0020B1B3;
    localparam logic [31:0] I_JAL  = 32'h0000006F;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Function code by mnemonic, looked up from funct3 plus the "alternate" bit.
    function automatic logic [5:0] fn_of(input logic [2:0] f3, input logic alt);
        logic [5:0] tab [8];
        tab[0] = alt ? 6'b010001 : 6'b010000; // ADD / SUB
        tab[1] = 6'b110000;                   // SLL
        tab[2] = 6'b000101;                   // SLT -> CMPLT
        tab[3] = 6'b000000;                   // unsigned compare: none
        tab[4] = 6'b100110;                   // XOR
        tab[5] = alt ? 6'b110011 : 6'b110001; // SRA / SRL
        tab[6] = 6'b101110;                   // OR
        tab[7] = 6'b101000;                   // AND
        return tab[f3];
    endfunction

    function automatic bund_t model(input logic [31:0] i);
        bund_t      b;
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       legal;
        logic       is_shift;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        b.rd = i[11:7]; b.rs1 = i[19:15]; b.rs2 = i[24:20];
        b.fn = 6'd0; b.imm = 32'd0; b.use_imm = 1'b0; b.illegal = 1'b1;
        if (op == 7'b0110011) begin
            legal = (f3 != 3'd3) && ((f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            if (legal) begin
                b.fn = fn_of(f3, f7 == 7'h20);
                b.illegal = 1'b0;
            end
        end else if (op == 7'b0010011) begin
            is_shift = (f3 == 3'd1) || (f3 == 3'd5);
            if (is_shift) legal = (f7 == 7'd0) || (f3 == 3'd5 && f7 == 7'h20);
            else          legal = (f3 != 3'd3);
            if (legal) begin
                b.fn = fn_of(f3, is_shift && f7 == 7'h20);
                b.illegal = 1'b0;
                b.use_imm = 1'b1;
                b.rs2 = 5'd0;
                if (is_shift) b.imm = 32'(i[24:20]);
                else          b.imm = 32'(int'($signed(i[31:20])));
            end
        end
        return b;
    endfunction

    task automatic check_state();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() != 0) begin
            chk("fn", 32'(out_fn), 32'(q[0].fn));
            chk("rs1", 32'(out_rs1), 32'(q[0].rs1));
            chk("rs2", 32'(out_rs2), 32'(q[0].rs2));
            chk("rd", 32'(out_rd), 32'(q[0].rd));
            chk("imm", out_imm, q[0].imm);
            chk("use_imm", 32'(out_use_imm), 32'(q[0].use_imm));
            chk("illegal", 32'(out_illegal), 32'(q[0].illegal));
        end
`ifdef ALU_DEC_PERF_EN
        chk("perf_decoded", perf_decoded, exp_dec);
        chk("perf_illegal", perf_illegal, exp_ill);
`endif
    endtask

    // One clock: drive inputs, update the model for the edge, check after it.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
        bit    in_fire;
        bit    out_fire;
        bund_t gone;
        in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
        in_fire  = iv && (q.size() < 2);
        out_fire = ordy && (q.size() != 0);
        @(posedge clk);
        if (out_fire) begin
            gone = q.pop_front();
            exp_dec++;
            if (gone.illegal) exp_ill++;
        end
        if (fl) q.delete();
        else if (in_fire) q.push_back(model(ins));
        #1;
        check_state();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  opc;
        logic [6:0]  f7;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4)      opc = 7'b0110011;
        else if (k < 8) opc = 7'b0010011;
        else            opc = 7'($urandom);
        k = $urandom_range(0, 9);
        if (k < 5)      f7 = 7'd0;
        else if (k < 8) f7 = 7'h20;
        else            f7 = 7'($urandom);
        return {f7, r[24:7], opc};
    endfunction

    initial begin
        n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_fn", 32'(out_fn), 32'd0);
        chk("rst out_imm", out_imm, 32'd0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst release in_ready", 32'(in_ready), 32'd1);
        check_state();

        // Directed decodes
        cycle(1'b1, I_ADD, 1'b1, 1'b0);
        chk("add fn", 32'(out_fn), 32'h10);
        chk("add rd", 32'(out_rd), 32'd3);
        chk("add rs2", 32'(out_rs2), 32'd2);
        cycle(1'b1, I_SRAI, 1'b1, 1'b0);
        chk("srai fn", 32'(out_fn), 32'h33);
        chk("srai imm", out_imm, 32'h3);
        chk("srai use_imm", 32'(out_use_imm), 32'd1);
        cycle(1'b1, I_ADDI, 1'b1, 1'b0);
        chk("addi imm", out_imm, 32'hFFFFFFFF);
        cycle(1'b1, I_SLTU, 1'b1, 1'b0);
        chk("sltu illegal", 32'(out_illegal), 32'd1);
        chk("sltu fn", 32'(out_fn), 32'd0);
        chk("sltu rd", 32'(out_rd), 32'd3);
        cycle(1'b1, I_JAL, 1'b1, 1'b0);
        chk("jal illegal", 32'(out_illegal), 32'd1);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        // Backpressure through the skid buffer
        cycle(1'b1, I_ADD, 1'b0, 1'b0);
        cycle(1'b1, I_SUB, 1'b0, 1'b0);
        chk("bp in_ready low", 32'(in_ready), 32'd0);
        cycle(1'b1, I_XOR, 1'b0, 1'b0);
        chk("bp hold fn", 32'(out_fn), 32'h10);
        cycle(1'b1, I_XOR, 1'b1, 1'b0);
        chk("bp second fn", 32'(out_fn), 32'h11);
        chk("bp in_ready back", 32'(in_ready), 32'd1);
        cycle(1'b1, I_XOR, 1'b1, 1'b0);
        chk("bp third fn", 32'(out_fn), 32'h26);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("bp drained", 32'(out_valid), 32'd0);

        // Flush with skid full, then flush discarding a handshaking input
        cycle(1'b1, I_ADD, 1'b0, 1'b0);
        cycle(1'b1, I_SUB, 1'b0, 1'b0);
        cycle(1'b1, I_XOR, 1'b0, 1'b1);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        cycle(1'b1, I_ADD, 1'b0, 1'b0);
        cycle(1'b1, I_AND, 1'b1, 1'b1);
        chk("flush drop input", 32'(out_valid), 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("flush nothing after", 32'(out_valid), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom_range(0, 3) != 0), rand_instr(),
                  ($urandom_range(0, 1) != 0), ($urandom_range(0, 24) == 0));
        end

        // Asynchronous reset in the middle of a stream
        cycle(1'b1, I_ADD, 1'b0, 1'b0);
        cycle(1'b1, I_SUB, 1'b0, 1'b0);
        in_valid = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        chk("midrst out_fn", 32'(out_fn), 32'd0);
`ifdef ALU_DEC_PERF_EN
        chk("midrst perf_decoded", perf_decoded, 32'd0);
        chk("midrst perf_illegal", perf_illegal, 32'd0);
`endif
        q.delete(); exp_dec = 0; exp_ill = 0;
        #3 n_rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_state();

        // Five legal and two illegal bundles drained downstream
        cycle(1'b1, I_ADD, 1'b1, 1'b0);
        cycle(1'b1, I_SLTU, 1'b1, 1'b0);
        cycle(1'b1, I_SUB, 1'b1, 1'b0);
        cycle(1'b1, I_SRAI, 1'b1, 1'b0);
        cycle(1'b1, I_JAL, 1'b1, 1'b0);
        cycle(1'b1, I_ADDI, 1'b1, 1'b0);
        cycle(1'b1, I_XOR, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("drain empty", 32'(out_valid), 32'd0);
`ifdef ALU_DEC_PERF_EN
        chk("perf 7 decoded", perf_decoded, 32'd7);
        chk("perf 2 illegal", perf_illegal, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
